// File: rtl/segway_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : segway_pkg                                                   |
// | Description : Shared types and constants for the Segway rider logic.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package segway_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        WAIT  = 2'b01,
        STEER = 2'b10
    } steer_state_t;

    localparam logic [11:0] MIN_RIDER_WT   = 12'h200;
    localparam logic [11:0] WT_HYST        = 12'h040;
    localparam int          DWELL_BITS_SIM = 15;
    localparam int          DWELL_BITS_HW  = 26;

endpackage : segway_pkg
`default_nettype wire

// File: rtl/steer_dwell_tmr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : steer_dwell_tmr                                              |
// | Description : Saturating dwell counter; full flags the all-ones value.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module steer_dwell_tmr #(
    parameter int WIDTH = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic full
);

    logic [WIDTH-1:0] r_cnt;

    // Clear has priority; the count parks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !full) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign full = &r_cnt;

endmodule : steer_dwell_tmr
`default_nettype wire

// File: rtl/steer_en_sm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : steer_en_sm                                                  |
// | Description : Rider-presence / steering-enable controller for the Segway.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module steer_en_sm #(
    parameter logic [11:0] MIN_RIDER_WT = segway_pkg::MIN_RIDER_WT,
    parameter logic [11:0] WT_HYST      = segway_pkg::WT_HYST,
    parameter bit          FAST_SIM     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        ld_vld,
    output logic        en_steer,
    output logic        rider_off,
    output logic [1:0]  state_dbg
);

    import segway_pkg::*;

    localparam int          c_dwell_bits = FAST_SIM ? DWELL_BITS_SIM : DWELL_BITS_HW;
    localparam logic [12:0] c_on_lim     = {1'b0, MIN_RIDER_WT};
    localparam logic [12:0] c_off_lim    = {1'b0, MIN_RIDER_WT - WT_HYST};

    logic [12:0]  r_sum;
    logic [11:0]  r_diff;
    logic         r_on_wt, r_off_wt, r_bal, r_foot_off;
    logic [12:0]  w_sum;
    logic [11:0]  w_diff;
    logic [16:0]  w_prod;
    steer_state_t r_state, w_state_nxt;
    logic         w_tmr_clr, w_tmr_inc, w_tmr_full;
    logic         r_en_steer, r_rider_off;

    // The sample in force this cycle: a fresh one on ld_vld, else the held one.
    always_comb begin
        w_sum  = r_sum;
        w_diff = r_diff;
        if (ld_vld) begin
            w_sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
            w_diff = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
        end
        w_prod = {4'b0000, w_sum} * 17'd15;
    end

    // Flags land one cycle after the strobe; reset values match an all-zero sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum      <= '0;
            r_diff     <= '0;
            r_on_wt    <= 1'b0;
            r_off_wt   <= 1'b1;
            r_bal      <= 1'b1;
            r_foot_off <= 1'b0;
        end else begin
            r_sum      <= w_sum;
            r_diff     <= w_diff;
            r_on_wt    <= (w_sum >= c_on_lim);
            r_off_wt   <= (w_sum < c_off_lim);
            r_bal      <= ({1'b0, w_diff} <= {4'b0000, w_sum[12:4]});
            r_foot_off <= ({1'b0, w_diff} > w_prod[16:4]);
        end
    end

    steer_dwell_tmr #(
        .WIDTH (c_dwell_bits)
    ) u_dwell_tmr (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_tmr_clr),
        .inc  (w_tmr_inc),
        .full (w_tmr_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_clr   = 1'b0;
        w_tmr_inc   = 1'b0;
        case (r_state)
            OFF: begin
                if (r_on_wt) begin
                    w_state_nxt = WAIT;
                    w_tmr_clr   = 1'b1;
                end
            end
            WAIT: begin
                if (r_off_wt) begin
                    w_state_nxt = OFF;
                end else if (!r_bal) begin
                    w_tmr_clr = 1'b1;
                end else if (w_tmr_full) begin
                    w_state_nxt = STEER;
                    w_tmr_clr   = 1'b1;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            STEER: begin
                // Losing weight outranks a lifted foot.
                if (r_off_wt) begin
                    w_state_nxt = OFF;
                end else if (r_foot_off) begin
                    w_state_nxt = WAIT;
                    w_tmr_clr   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = OFF;
                w_tmr_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= OFF;
            r_en_steer  <= 1'b0;
            r_rider_off <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_en_steer  <= (w_state_nxt == STEER);
            r_rider_off <= (w_state_nxt == OFF);
        end
    end

    assign en_steer  = r_en_steer;
    assign rider_off = r_rider_off;
    assign state_dbg = r_state;

endmodule : steer_en_sm
`default_nettype wire

// File: tb/tb_steer_en_sm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_steer_en_sm                                               |
// | Description : Randomized self-checking bench for steer_en_sm (FAST_SIM).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_steer_en_sm;

    localparam int DWELL = 32768;
    localparam int RND_NONE = 0, RND_ANY = 1, RND_BAL = 2, RND_MOD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic        ld_vld = 1'b0;
    logic        en_steer, rider_off;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    steer_en_sm #(
        .FAST_SIM (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .ld_vld    (ld_vld),
        .en_steer  (en_steer),
        .rider_off (rider_off),
        .state_dbg (state_dbg)
    );

    int n_vec = 0, n_err = 0;
    int cyc = 0, vld_cyc = -1000, rnd_mode = RND_NONE;

    // Reference: rider phase (0 off, 1 waiting, 2 steering), balanced-cycle run
    // length while waiting, and the conditions of the last sample seen.
    int m_phase = 0, m_run = 0;
    bit m_on = 0, m_off = 1, m_bal = 1, m_foot = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic pick_loads(input int mode);
        int l, r, s, d;
        do begin
            if (mode == RND_ANY) begin
                l = $urandom_range(0, 511);
                r = $urandom_range(0, 511);
            end else if (mode == RND_BAL) begin
                l = $urandom_range(256, 3584);
                r = l + $urandom_range(0, l / 9) * (($urandom_range(0, 1) != 0) ? 1 : -1);
            end else begin
                l = $urandom_range(0, 4095);
                r = $urandom_range(0, 4095);
            end
            s = l + r;
            d = absdiff(l, r);
        end while ((mode == RND_BAL && !(s >= 512 && d <= s / 16)) ||
                   (mode == RND_MOD && !(s >= 448 && d <= (s * 15) / 16)));
        lft_ld  = 12'(l);
        rght_ld = 12'(r);
    endtask

    task automatic tick();
        int s, d;
        logic [3:0] exp_v;
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_run = 0;
            m_on = 0; m_off = 1; m_bal = 1; m_foot = 0;
        end else begin
            if (m_phase == 0) begin
                if (m_on) begin m_phase = 1; m_run = 0; end
            end else if (m_phase == 1) begin
                if (m_off) m_phase = 0;
                else if (!m_bal) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == DWELL) begin m_phase = 2; m_run = 0; end
                end
            end else begin
                if (m_off) m_phase = 0;
                else if (m_foot) begin m_phase = 1; m_run = 0; end
            end
            if (ld_vld) begin
                s = int'(lft_ld) + int'(rght_ld);
                d = absdiff(int'(lft_ld), int'(rght_ld));
                m_on   = (s >= 512);
                m_off  = (s < 448);
                m_bal  = (d <= s / 16);
                m_foot = (d > (s * 15) / 16);
            end
        end
        #1;
        cyc++;
        exp_v = {2'(m_phase), m_phase == 2, m_phase == 0};
        chk("outputs", {28'd0, state_dbg, en_steer, rider_off}, {28'd0, exp_v});
        ld_vld = ((cyc % 64) == 0);
        if (ld_vld) begin
            vld_cyc = cyc;
            if (rnd_mode != RND_NONE) pick_loads(rnd_mode);
        end
    endtask

    // Present one sample and return two cycles after its strobe.
    task automatic sample(input logic [11:0] l, input logic [11:0] r);
        int start;
        if (ld_vld) tick();
        lft_ld  = l;
        rght_ld = r;
        start   = vld_cyc;
        while (vld_cyc == start) tick();
        tick();
        tick();
    endtask

    task automatic wait_rise(input int budget);
        int b = 0;
        while (en_steer !== 1'b1 && b < budget) begin
            tick();
            b++;
        end
    endtask

    initial begin
        int w, v2, vr, b;

        rst = 1'b1;
        repeat (4) tick();
        chk("rst_state", state_dbg, 2'b00);
        chk("rst_en", en_steer, 1'b0);
        chk("rst_rider_off", rider_off, 1'b1);
        rst = 1'b0;
        repeat (200) tick();
        chk("idle_empty", {state_dbg, en_steer, rider_off}, 4'b0001);

        rnd_mode = RND_ANY;
        repeat (40 * 64) tick();
        rnd_mode = RND_NONE;
        lft_ld = '0; rght_ld = '0;
        repeat (192) tick();
        chk("pre_mount_off", state_dbg, 2'b00);

        // Mount, interrupt the dwell with one unbalanced sample, rebalance.
        lft_ld = 12'h180; rght_ld = 12'h180;
        b = 0;
        while (rider_off === 1'b1 && b < 200) begin tick(); b++; end
        chk("mount_latency", cyc - vld_cyc, 2);
        w = cyc;
        rnd_mode = RND_BAL;
        while (!(ld_vld && cyc >= w + 1000)) tick();
        rnd_mode = RND_NONE;
        lft_ld = 12'h1C0; rght_ld = 12'h140;
        tick();
        while (!ld_vld) tick();
        lft_ld = 12'h180; rght_ld = 12'h180;
        v2 = cyc;
        rnd_mode = RND_BAL;
        chk("imbal_stays_wait", state_dbg, 2'b01);
        wait_rise(40000);
        chk("dwell_restart", cyc - v2, DWELL + 1);

        rnd_mode = RND_MOD;
        repeat (512) tick();
        rnd_mode = RND_NONE;
        chk("steer_rand_mod", state_dbg, 2'b10);
        sample(12'h100, 12'h1C0);
        chk("steer_mod_imbal", state_dbg, 2'b10);
        sample(12'h0F0, 12'h0F0);
        chk("steer_hyst_1e0", state_dbg, 2'b10);
        sample(12'h010, 12'h300);
        chk("foot_off_state", state_dbg, 2'b01);
        chk("foot_off_en", en_steer, 1'b0);
        chk("foot_off_rider", rider_off, 1'b0);
        sample(12'h100, 12'h100);
        vr = vld_cyc;
        rnd_mode = RND_BAL;
        wait_rise(40000);
        chk("redwell", cyc - vr, DWELL + 1);

        rnd_mode = RND_NONE;
        lft_ld = 12'h100; rght_ld = 12'h100;
        repeat (70) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_state", state_dbg, 2'b00);
        chk("rst_mid_en", en_steer, 1'b0);
        chk("rst_mid_rider", rider_off, 1'b1);
        tick();
        rst = 1'b0;
        sample(12'h100, 12'h100);
        chk("post_rst_wait", state_dbg, 2'b01);
        rnd_mode = RND_BAL;
        repeat (4096) tick();
        rnd_mode = RND_NONE;
        chk("no_partial_dwell", en_steer, 1'b0);

        sample(12'h0F0, 12'h0F0);
        chk("hyst_wait_1e0", state_dbg, 2'b01);
        sample(12'h0D8, 12'h0D8);
        chk("hyst_1b0_off", {state_dbg, rider_off}, 3'b001);
        sample(12'h0F8, 12'h0F8);
        chk("hyst_1f0_stay", state_dbg, 2'b00);
        sample(12'h100, 12'h100);
        chk("hyst_200_wait", state_dbg, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_steer_en_sm
`default_nettype wire
